// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, funct
// codes, ALUOp encodings, ALU control codes and the controller state enum.
package mips_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes driven to the shared ALU
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp: how the ALU decoder chooses the operation
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Controller states; HALT sits apart from the working states so it is
    // easy to spot on a waveform and cannot be reached by a counting slip.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    // True for the last state of every supported instruction; leaving one of
    // these for FETCH retires an instruction.
    function automatic logic is_final_state(input state_t s);
        case (s)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field onto the ALU control code.
module ALU_Decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    // Select the ALU operation; unknown funct codes fall back to add
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred when a branch forgets an assignment.
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_control_o = ALU_ADD;
                    FN_SUB:  alu_control_o = ALU_SUB;
                    FN_AND:  alu_control_o = ALU_AND;
                    FN_OR:   alu_control_o = ALU_OR;
                    FN_SLT:  alu_control_o = ALU_SLT;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU and unified memory
// datapath one state per cycle and counts retired instructions.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [1:0]  pc_src,
    output logic        pc_en,
    output logic        halted,
    output logic [31:0] instret
);

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    alu_op_t     alu_op;
    logic        pc_write;
    logic        branch;

    // State and retire counter registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // values from before the edge, independent of statement order.
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next state and Moore control outputs decoded from the current state
    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+1 is computed every FETCH cycle, but only committed
                // together with the instruction load when run allows it.
                iord      = 1'b0;
                alu_src_a = 1'b0;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_ADD;
                pc_src    = 2'b00;
                if (run) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target (PC+1 + SignImm) in ALUOut
                alu_src_a = 1'b0;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_dst    = 1'b0;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                // Parked until reset; every strobe stays low
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // PC load: unconditional writes, or a taken beq using the live zero flag
    always_comb begin
        pc_en = pc_write | (branch & zero);
    end

    // Retire count advances when a completed instruction hands back to FETCH
    always_comb begin
        instret_d = instret_q;
        if (is_final_state(state_q) && (state_d == S_FETCH)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    assign instret = instret_q;

    ALU_Decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (funct),
        .alu_control_o (alu_control)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// through its states and compares every control output per cycle against
// hand-written control words.
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        iord;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic [1:0]  pc_src;
    logic        pc_en;
    logic        halted;
    logic [31:0] instret;

    int n_checks;
    int n_fail;

    // Control word layout:
    // iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    // alu_src_b[1:0], alu_control[2:0], pc_src[1:0], pc_en, halted
    localparam logic [15:0] W_FETCH_RUN  = 16'b0_0_1_0_0_0_0_01_010_00_1_0;
    localparam logic [15:0] W_FETCH_IDLE = 16'b0_0_0_0_0_0_0_01_010_00_0_0;
    localparam logic [15:0] W_DECODE     = 16'b0_0_0_0_0_0_0_10_010_00_0_0;
    localparam logic [15:0] W_MEMADR     = 16'b0_0_0_0_0_0_1_10_010_00_0_0;
    localparam logic [15:0] W_MEMRD      = 16'b1_0_0_0_0_0_0_00_010_00_0_0;
    localparam logic [15:0] W_MEMWB      = 16'b0_0_0_0_1_1_0_00_010_00_0_0;
    localparam logic [15:0] W_MEMWR      = 16'b1_1_0_0_0_0_0_00_010_00_0_0;
    localparam logic [15:0] W_EXEC_SLT   = 16'b0_0_0_0_0_0_1_00_111_00_0_0;
    localparam logic [15:0] W_EXEC_SUB   = 16'b0_0_0_0_0_0_1_00_110_00_0_0;
    localparam logic [15:0] W_ALUWB      = 16'b0_0_0_1_0_1_0_00_010_00_0_0;
    localparam logic [15:0] W_BRANCH_NT  = 16'b0_0_0_0_0_0_1_00_110_01_0_0;
    localparam logic [15:0] W_BRANCH_T   = 16'b0_0_0_0_0_0_1_00_110_01_1_0;
    localparam logic [15:0] W_ADDIEX     = 16'b0_0_0_0_0_0_1_10_010_00_0_0;
    localparam logic [15:0] W_ADDIWB     = 16'b0_0_0_0_0_1_0_00_010_00_0_0;
    localparam logic [15:0] W_JUMP       = 16'b0_0_0_0_0_0_0_00_010_10_1_0;
    localparam logic [15:0] W_HALT       = 16'b0_0_0_0_0_0_0_00_010_00_0_1;

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .halted      (halted),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Settle combinational outputs, then compare the whole control word
    task automatic expect_ctrl(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        #1;
        obs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_control, pc_src, pc_en, halted};
        check(tag, {16'd0, obs}, {16'd0, exp});
    endtask

    // Advance one clock; inputs are changed well after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        run      = 1'b0;
        opcode   = 6'b000000;
        funct    = 6'b000000;
        zero     = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        expect_ctrl("reset_fetch_idle", W_FETCH_IDLE);
        check("reset_instret", instret, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);

        // lw: 5 cycles
        run = 1'b1; opcode = 6'b100011;
        expect_ctrl("lw_fetch", W_FETCH_RUN);   tick();
        expect_ctrl("lw_decode", W_DECODE);     tick();
        expect_ctrl("lw_memadr", W_MEMADR);     tick();
        expect_ctrl("lw_memrd", W_MEMRD);       tick();
        expect_ctrl("lw_memwb", W_MEMWB);
        check("lw_instret_before", instret, 32'd0);
        tick();
        check("lw_instret", instret, 32'd1);

        // sw: 4 cycles, reg_write never asserted
        opcode = 6'b101011;
        expect_ctrl("sw_fetch", W_FETCH_RUN);   tick();
        expect_ctrl("sw_decode", W_DECODE);     tick();
        expect_ctrl("sw_memadr", W_MEMADR);     tick();
        expect_ctrl("sw_memwr", W_MEMWR);       tick();
        check("sw_instret", instret, 32'd2);

        // beq taken
        opcode = 6'b000100; zero = 1'b1;
        expect_ctrl("beqt_fetch", W_FETCH_RUN); tick();
        expect_ctrl("beqt_decode", W_DECODE);   tick();
        expect_ctrl("beqt_branch", W_BRANCH_T); tick();
        check("beqt_instret", instret, 32'd3);

        // beq not taken, and pc_en following zero combinationally
        zero = 1'b0;
        expect_ctrl("beqn_fetch", W_FETCH_RUN); tick();
        expect_ctrl("beqn_decode", W_DECODE);   tick();
        expect_ctrl("beqn_branch", W_BRANCH_NT);
        zero = 1'b1;
        expect_ctrl("beqn_zero_rise", W_BRANCH_T);
        zero = 1'b0;
        expect_ctrl("beqn_zero_fall", W_BRANCH_NT);
        tick();
        check("beqn_instret", instret, 32'd4);

        // R-type slt
        opcode = 6'b000000; funct = 6'b101010;
        expect_ctrl("slt_fetch", W_FETCH_RUN);  tick();
        expect_ctrl("slt_decode", W_DECODE);    tick();
        expect_ctrl("slt_exec", W_EXEC_SLT);    tick();
        expect_ctrl("slt_aluwb", W_ALUWB);      tick();
        check("slt_instret", instret, 32'd5);

        // R-type sub
        funct = 6'b100010;
        expect_ctrl("sub_fetch", W_FETCH_RUN);  tick();
        expect_ctrl("sub_decode", W_DECODE);    tick();
        expect_ctrl("sub_exec", W_EXEC_SUB);    tick();
        expect_ctrl("sub_aluwb", W_ALUWB);      tick();
        check("sub_instret", instret, 32'd6);

        // j
        opcode = 6'b000010; funct = 6'b000000;
        expect_ctrl("j_fetch", W_FETCH_RUN);    tick();
        expect_ctrl("j_decode", W_DECODE);      tick();
        expect_ctrl("j_jump", W_JUMP);          tick();
        check("j_instret", instret, 32'd7);

        // addi with run dropped mid-instruction: it still completes
        opcode = 6'b001000;
        expect_ctrl("addi_fetch", W_FETCH_RUN); tick();
        run = 1'b0;
        expect_ctrl("addi_decode", W_DECODE);   tick();
        expect_ctrl("addi_ex", W_ADDIEX);       tick();
        expect_ctrl("addi_wb", W_ADDIWB);       tick();
        check("addi_instret", instret, 32'd8);

        // run=0 holds FETCH for 10 cycles
        for (int i = 0; i < 10; i++) begin
            expect_ctrl($sformatf("idle_%0d", i), W_FETCH_IDLE);
            tick();
        end
        check("idle_instret", instret, 32'd8);

        // Reset in MEMRD aborts the load
        run = 1'b1; opcode = 6'b100011;
        expect_ctrl("abort_fetch", W_FETCH_RUN); tick();
        expect_ctrl("abort_decode", W_DECODE);   tick();
        expect_ctrl("abort_memadr", W_MEMADR);   tick();
        expect_ctrl("abort_memrd", W_MEMRD);
        rst = 1'b1; run = 1'b0;
        tick();
        rst = 1'b0;
        expect_ctrl("abort_after_rst", W_FETCH_IDLE);
        check("abort_instret", instret, 32'd0);
        tick();
        expect_ctrl("abort_still_idle", W_FETCH_IDLE);

        // Unknown opcode halts; strobes stay low and instret frozen
        run = 1'b1; opcode = 6'b001000;
        expect_ctrl("pre_fetch", W_FETCH_RUN);  tick();
        expect_ctrl("pre_decode", W_DECODE);    tick();
        expect_ctrl("pre_ex", W_ADDIEX);        tick();
        expect_ctrl("pre_wb", W_ADDIWB);        tick();
        check("pre_instret", instret, 32'd1);
        opcode = 6'b111111;
        expect_ctrl("halt_fetch", W_FETCH_RUN); tick();
        expect_ctrl("halt_decode", W_DECODE);   tick();
        for (int i = 0; i < 20; i++) begin
            expect_ctrl($sformatf("halt_%0d", i), W_HALT);
            tick();
        end
        check("halt_instret", instret, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_ctrl("halt_exit_fetch", W_FETCH_RUN);
        check("halt_exit_instret", instret, 32'd0);
        check("halt_exit_halted", {31'd0, halted}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus process ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM that sequences the MIPS datapath through a single shared ALU and a single unified memory, replacing the single-cycle Main_Decoder. It decodes the latched instruction opcode and drives, state by state, every datapath enable and mux select, including the PC write-enable and the register-file and memory write strobes. Supported instructions are R-type, lw, sw, beq, addi and j. The PC is word-addressed (PC+1 increments).

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  allow a new fetch; sampled only in FETCH
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  register-file write address: 0 = rt, 1 = rd
- mem_to_reg  out  1  register-file write data: 0 = ALUOut, 1 = data register
- reg_write  out  1  register-file write strobe
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B operand: 00 = register B, 01 = constant 1, 10 = SignImm
- alu_control  out  3  ALU operation
- pc_src  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC register load
- halted  out  1  FSM is in HALT
- instret  out  32  count of retired instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- All outputs are Moore (decoded from state), with two exceptions:
  - pc_en = pc_write | (branch & zero).
  - run gates FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - Drives iord=0, alu_src_a=0, alu_src_b=01, ALUOp=00, pc_src=00.
  - If run=1: ir_write=1, pc_write=1, next state DECODE.
  - If run=0: ir_write=0, pc_write=0, stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=10, ALUOp=00. Next state by opcode:
  - lw (100011) and sw (101011) go to MEMADR.
  - R-type (000000) goes to EXEC.
  - beq (000100) goes to BRANCH.
  - addi (001000) goes to ADDIEX.
  - j (000010) goes to JUMP.
  - Any other opcode goes to HALT.
- MEMADR: alu_src_a=1, alu_src_b=10, ALUOp=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_write=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, ALUOp=10, then ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=01, pc_src=01, branch=1, then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ALUOp=00, then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JUMP: pc_src=10, pc_write=1, then FETCH.
- HALT: all strobes 0, halted=1. Exits only via rst.
- ALUOp to alu_control mapping:
  - 00 gives 010 (add).
  - 01 gives 110 (sub).
  - 10 decodes funct: 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111; any other funct gives 010.
- instret increments by 1 on each transition from a final state (MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP) into FETCH. It wraps modulo 2^32 and does not count entry into HALT.

## Timing
- Reset:
  - On a rising edge with rst=1: state is FETCH, instret=0, halted=0.
  - rst overrides any in-progress instruction; no strobe is asserted in the cycle after that edge unless FETCH with run=1.
  - Strobes in an aborted state are not completed.
- Cycles per instruction, counting FETCH:
  - beq and j take 3.
  - R-type, addi and sw take 4.
  - lw takes 5.
- ir_write and pc_en are high in the same FETCH cycle. opcode is valid from DECODE onward.
- pc_en in BRANCH depends combinationally on zero in the same cycle.
- A run change mid-instruction has no effect until the next FETCH.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the state enum, with HALT given a distinct encoding;
  - the ALUOp encodings;
  - the funct constants.
- One sub-module: reuse the existing ALU_Decoder (ALUOp, funct to alu_control) instantiated internally. No other hierarchy.

## Test plan
- Reset then run=1 with opcode=100011 (lw): the state sequence is FETCH→DECODE→MEMADR→MEMRD→MEMWB→FETCH; reg_write=1 and mem_to_reg=1 only in cycle 5; instret goes 0→1.
- sw (101011): mem_write=1 and iord=1 in cycle 4 only; reg_write is never asserted.
- beq (000100) in cycle 3: with zero=1, pc_en=1 and pc_src=01; with zero=0, pc_en=0. Both cases return to FETCH and increment instret.
- R-type with funct=101010: alu_control=111 in EXEC, reg_dst=1 and reg_write=1 in ALUWB. With funct=100010: alu_control=110.
- Opcode 111111 in DECODE: HALT next cycle; halted=1 and all strobes stay 0 for 20 cycles; instret unchanged; rst returns the FSM to FETCH with instret=0.
- run=0 for 10 cycles: FETCH is held with ir_write=0 and pc_en=0. Asserting rst in MEMRD yields FETCH next cycle with no reg_write.
